// File: rtl/cpu7_ifu_ibuf_pkg.sv
// Shared IFU constants used by the instruction buffer and its bench.
// The NOP word is what decode sees whenever the buffer is empty.
package cpu7_ifu_ibuf_pkg;

  localparam int          GRLEN_DEFAULT   = 32;
  localparam int          IBUF_DEPTH_DFLT = 4;
  localparam logic [31:0] LSOC1K_NOP_INST = 32'h0340_0000;

endpackage

// File: rtl/cpu7_ifu_ibuf_if.sv
// Fetch-to-decode bundle around the instruction buffer.
// The master side is fetch plus decode control; the slave side is the buffer.
interface cpu7_ifu_ibuf_if #(
  parameter int DEPTH = 4,
  parameter int GRLEN = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             fdp_ibuf_valid;
  logic [31:0]      fdp_ibuf_inst;
  logic [GRLEN-1:0] fdp_ibuf_pc;
  logic             fdp_ibuf_excp;
  logic             ibuf_fdp_ready;

  logic             ifu_exu_valid_d;
  logic [31:0]      ifu_exu_inst_d;
  logic [GRLEN-1:0] ifu_exu_pc_d;
  logic             ifu_exu_excp_d;
  logic             exu_ifu_stall;
  logic             exu_ifu_flush;

  logic [CW-1:0]    ibuf_count;

  modport master (
    output fdp_ibuf_valid, fdp_ibuf_inst, fdp_ibuf_pc, fdp_ibuf_excp,
    output exu_ifu_stall, exu_ifu_flush,
    input  ibuf_fdp_ready, ifu_exu_valid_d, ifu_exu_inst_d, ifu_exu_pc_d,
    input  ifu_exu_excp_d, ibuf_count
  );

  modport slave (
    input  fdp_ibuf_valid, fdp_ibuf_inst, fdp_ibuf_pc, fdp_ibuf_excp,
    input  exu_ifu_stall, exu_ifu_flush,
    output ibuf_fdp_ready, ifu_exu_valid_d, ifu_exu_inst_d, ifu_exu_pc_d,
    output ifu_exu_excp_d, ibuf_count
  );
endinterface

// File: rtl/cpu7_ifu_ibuf.sv
// IFU instruction buffer: small FIFO of {inst, pc, excp} between fetch and decode.
// Head outputs come only from registered storage and pointers; flush empties it.
module cpu7_ifu_ibuf
  import cpu7_ifu_ibuf_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH_DFLT,
  parameter int GRLEN = GRLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  cpu7_ifu_ibuf_if.slave    bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]      inst_mem [DEPTH];
  logic [GRLEN-1:0] pc_mem   [DEPTH];
  logic             excp_mem [DEPTH];

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic ready;
  logic valid;
  logic push;
  logic pop;

  assign ready = (cnt_q != CW'(DEPTH));
  assign valid = (cnt_q != '0);

  always_comb begin
    push  = bus.fdp_ibuf_valid & ready & ~bus.exu_ifu_flush;
    pop   = valid & ~bus.exu_ifu_stall & ~bus.exu_ifu_flush;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (bus.exu_ifu_flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + PW'(1);
      if (pop)  rp_d = rp_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage has no reset so inst/pc can map onto LUTRAM.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wp_q] <= bus.fdp_ibuf_inst;
      pc_mem[wp_q]   <= bus.fdp_ibuf_pc;
      excp_mem[wp_q] <= bus.fdp_ibuf_excp;
    end
  end

  assign bus.ibuf_fdp_ready  = ready;
  assign bus.ifu_exu_valid_d = valid;
  assign bus.ifu_exu_inst_d  = valid ? inst_mem[rp_q] : LSOC1K_NOP_INST;
  assign bus.ifu_exu_pc_d    = valid ? pc_mem[rp_q]   : '0;
  assign bus.ifu_exu_excp_d  = valid ? excp_mem[rp_q] : 1'b0;
  assign bus.ibuf_count      = cnt_q;

endmodule

// File: tb/tb_cpu7_ifu_ibuf.sv
// Directed bench for cpu7_ifu_ibuf: vector table plus wrap and async-reset sequences.
module tb_cpu7_ifu_ibuf;
  import cpu7_ifu_ibuf_pkg::*;

  localparam int DEPTH = 4;
  localparam int GRLEN = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cpu7_ifu_ibuf_if #(.DEPTH(DEPTH), .GRLEN(GRLEN)) bus ();

  cpu7_ifu_ibuf #(.DEPTH(DEPTH), .GRLEN(GRLEN)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        excp;
    logic        stall;
    logic        flush;
    logic [2:0]  e_cnt;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_excp;
    logic        e_ready;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];
  logic [31:0] model_q[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h2a5a_0000;
  endfunction

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic excp,
                              input logic stall, input logic flush, input logic [2:0] e_cnt,
                              input logic e_valid, input logic [31:0] e_pc,
                              input logic e_excp, input logic e_ready);
    vec_t r;
    r.v = v; r.pc = pc; r.excp = excp; r.stall = stall; r.flush = flush;
    r.e_cnt = e_cnt; r.e_valid = e_valid; r.e_pc = e_pc; r.e_excp = e_excp;
    r.e_ready = e_ready;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic e_valid, input logic [31:0] e_pc,
                            input logic e_excp);
    check({tag, " valid"}, 32'(bus.ifu_exu_valid_d), 32'(e_valid));
    check({tag, " pc"},    bus.ifu_exu_pc_d,   e_valid ? e_pc : 32'h0);
    check({tag, " inst"},  bus.ifu_exu_inst_d, e_valid ? inst_of(e_pc) : LSOC1K_NOP_INST);
    check({tag, " excp"},  32'(bus.ifu_exu_excp_d), e_valid ? 32'(e_excp) : 32'h0);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic excp,
                       input logic stall, input logic flush);
    bus.fdp_ibuf_valid = v;
    bus.fdp_ibuf_pc    = pc;
    bus.fdp_ibuf_inst  = inst_of(pc);
    bus.fdp_ibuf_excp  = excp;
    bus.exu_ifu_stall  = stall;
    bus.exu_ifu_flush  = flush;
  endtask

  // Wrap sequence: a queue model predicts head and occupancy.
  task automatic model_cycle(input logic v, input logic [31:0] pc, input logic stall,
                             input int idx);
    string tag;
    tag = $sformatf("wrap%0d", idx);
    drive(v, pc, 1'b0, stall, 1'b0);
    #1;
    if (model_q.size() != 0) check_head(tag, 1'b1, model_q[0], 1'b0);
    else                     check_head(tag, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    if (model_q.size() != 0 && !stall) void'(model_q.pop_front());
    if (v && model_q.size() < DEPTH + (stall ? 0 : 1) && (model_q.size() + (stall ? 0 : 1)) <= DEPTH)
      model_q.push_back(pc);
    #1;
    check({tag, " count"}, 32'(bus.ibuf_count), 32'(model_q.size()));
  endtask

  localparam logic [31:0] P0 = 32'h1c00_0000;

  initial begin
    logic [31:0] wpc;
    int k;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // fill with stall, fifth push refused; then drain in order
    vecs.push_back(mk(1, P0+0,  0, 1, 0, 3'd1, 1, P0+0,  0, 1));
    vecs.push_back(mk(1, P0+4,  0, 1, 0, 3'd2, 1, P0+0,  0, 1));
    vecs.push_back(mk(1, P0+8,  0, 1, 0, 3'd3, 1, P0+0,  0, 1));
    vecs.push_back(mk(1, P0+12, 0, 1, 0, 3'd4, 1, P0+0,  0, 0));
    vecs.push_back(mk(1, P0+16, 0, 1, 0, 3'd4, 1, P0+0,  0, 0));
    vecs.push_back(mk(0, 0,     0, 0, 0, 3'd3, 1, P0+4,  0, 1));
    vecs.push_back(mk(0, 0,     0, 0, 0, 3'd2, 1, P0+8,  0, 1));
    vecs.push_back(mk(0, 0,     0, 0, 0, 3'd1, 1, P0+12, 0, 1));
    vecs.push_back(mk(0, 0,     0, 0, 0, 3'd0, 0, 0,     0, 1));
    // concurrent push and pop at count 2
    vecs.push_back(mk(1, P0+16, 0, 1, 0, 3'd1, 1, P0+16, 0, 1));
    vecs.push_back(mk(1, P0+20, 0, 1, 0, 3'd2, 1, P0+16, 0, 1));
    vecs.push_back(mk(1, P0+24, 0, 0, 0, 3'd2, 1, P0+20, 0, 1));
    vecs.push_back(mk(0, 0,     0, 0, 0, 3'd1, 1, P0+24, 0, 1));
    vecs.push_back(mk(0, 0,     0, 0, 0, 3'd0, 0, 0,     0, 1));
    // flush beats same-cycle push and pop; next push accepted
    vecs.push_back(mk(1, P0+28, 0, 1, 0, 3'd1, 1, P0+28, 0, 1));
    vecs.push_back(mk(1, P0+32, 0, 1, 0, 3'd2, 1, P0+28, 0, 1));
    vecs.push_back(mk(1, P0+36, 0, 1, 0, 3'd3, 1, P0+28, 0, 1));
    vecs.push_back(mk(1, P0+40, 0, 0, 1, 3'd0, 0, 0,     0, 1));
    vecs.push_back(mk(1, P0+44, 0, 1, 0, 3'd1, 1, P0+44, 0, 1));
    vecs.push_back(mk(0, 0,     0, 0, 0, 3'd0, 0, 0,     0, 1));
    // exception tag travels with its entry
    vecs.push_back(mk(1, P0+256, 0, 1, 0, 3'd1, 1, P0+256, 0, 1));
    vecs.push_back(mk(1, P0+260, 1, 1, 0, 3'd2, 1, P0+256, 0, 1));
    vecs.push_back(mk(1, P0+264, 0, 1, 0, 3'd3, 1, P0+256, 0, 1));
    vecs.push_back(mk(0, 0,      0, 0, 0, 3'd2, 1, P0+260, 1, 1));
    vecs.push_back(mk(0, 0,      0, 0, 0, 3'd1, 1, P0+264, 0, 1));
    vecs.push_back(mk(0, 0,      0, 0, 0, 3'd0, 0, 0,      0, 1));

    #12;
    check_head("reset", 1'b0, 32'h0, 1'b0);
    check("reset ready", 32'(bus.ibuf_fdp_ready), 32'h1);
    check("reset count", 32'(bus.ibuf_count), 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // empty buffer must not forward fetch input combinationally
    drive(1'b1, 32'h1c00_0f00, 1'b1, 1'b0, 1'b0);
    #1;
    check_head("nobypass", 1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].v, vecs[i].pc, vecs[i].excp, vecs[i].stall, vecs[i].flush);
      @(posedge clk); #1;
      check({tag, " count"}, 32'(bus.ibuf_count), 32'(vecs[i].e_cnt));
      check({tag, " ready"}, 32'(bus.ibuf_fdp_ready), 32'(vecs[i].e_ready));
      check_head(tag, vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_excp);
    end

    // wrap: count oscillates 1..3 across many pointer wraps
    wpc = 32'h1c00_1000;
    k = 0;
    model_cycle(1'b1, wpc, 1'b1, k++); wpc += 4;
    for (int i = 0; i < 10; i++) begin
      model_cycle(1'b1, wpc, 1'b0, k++); wpc += 4;
      if ((i % 4) < 2) begin
        model_cycle(1'b1, wpc, 1'b1, k++); wpc += 4;
      end else begin
        model_cycle(1'b0, 32'h0, 1'b0, k++);
      end
    end
    for (int i = 0; i < 4; i++) model_cycle(1'b0, 32'h0, 1'b0, k++);

    // async reset mid-stream, no clock edge in between
    drive(1'b1, 32'h1c00_2000, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 32'h1c00_2004, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("pre-reset count", 32'(bus.ibuf_count), 32'h2);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 resetn = 1'b0;
    #1;
    check_head("async reset", 1'b0, 32'h0, 1'b0);
    check("async reset ready", 32'(bus.ibuf_fdp_ready), 32'h1);
    check("async reset count", 32'(bus.ibuf_count), 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check("post-reset count", 32'(bus.ibuf_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu7_ifu_ibuf.md
# cpu7_ifu_ibuf

Instruction buffer between the fetch datapath and the decode stage of the IFU. Captures fetched {pc, inst, fetch-exception} triples into a small FIFO and presents the head entry as the decode-stage instruction (`ifu_exu_inst_d`, `ifu_exu_pc_d`). The immediate/offset decode logic consumes `ifu_exu_inst_d` directly. Absorbs decode stalls without stalling the fetch pipeline for up to DEPTH entries, and discards all contents on a branch/exception redirect.

## Interface
Parameters:
- DEPTH, 4: entry count; power of two, ≥ 2
- GRLEN, 32: PC width; the codebase `GRLEN`

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- fdp_ibuf_valid  in  1  fetch presents an instruction this cycle
- fdp_ibuf_inst  in  32  fetched instruction word
- fdp_ibuf_pc  in  GRLEN  PC of the fetched instruction
- fdp_ibuf_excp  in  1  fetch exception (ADEF/TLB) attached to this entry
- ibuf_fdp_ready  out  1  buffer can accept a write this cycle
- ifu_exu_valid_d  out  1  head entry valid for decode
- ifu_exu_inst_d  out  32  head instruction word
- ifu_exu_pc_d  out  GRLEN  head PC
- ifu_exu_excp_d  out  1  head fetch-exception flag
- exu_ifu_stall  in  1  decode does not consume the head this cycle
- exu_ifu_flush  in  1  redirect; empty the buffer
- ibuf_count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH entries of {inst, pc, excp}; write pointer `wp`, read pointer `rp`, counter `cnt`; pointers log2(DEPTH) bits and wrap naturally.
- push = fdp_ibuf_valid & ibuf_fdp_ready & !exu_ifu_flush.
- pop = ifu_exu_valid_d & !exu_ifu_stall & !exu_ifu_flush.
- ibuf_fdp_ready = (cnt != DEPTH). No write-when-full, even with a same-cycle pop.
- push only: entry[wp] written, wp+1, cnt+1. pop only: rp+1, cnt−1. push & pop: both pointers advance, cnt unchanged.
- Flush: wp, rp, cnt ← 0 next edge. Same-cycle push and pop are dropped. Flush wins over every other event.
- ifu_exu_valid_d = (cnt != 0). Head fields = entry[rp] when valid. When empty, inst_d = `LSOC1K_NOP_INST` (32'h03400000), pc_d = 0, excp_d = 0, so downstream decode sees a benign word.
- Entries carrying excp=1 flow like normal entries. The buffer does not interpret them.
- No fetch-to-decode bypass: an empty buffer does not forward the input combinationally.

## Timing
- Reset (async assert, sync-safe deassert on clk): cnt=0, wp=rp=0, valid_d=0, inst_d=NOP, pc_d=0, excp_d=0, ready=1, ibuf_count=0. Storage contents are don't-care.
- Write latency: entry pushed at edge N is visible at the head from cycle N+1, when it is the oldest entry.
- Throughput: one push and one pop per cycle sustained. Occupancy stays constant in steady state.
- Head outputs are a mux on registered storage and `rp`. No combinational path from `fdp_*` or `exu_ifu_stall` to the head outputs.
- ready depends only on registered `cnt`. No path from `exu_ifu_stall` to `ibuf_fdp_ready`.
- Flush at edge N: valid_d=0 and ready=1 in cycle N+1. A push in cycle N+1 is accepted normally.
- Reset asserted mid-operation: all state clears immediately, regardless of clk.

## Structure
- `GRLEN` and the new `LSOC1K_NOP_INST` constant live in the shared `common.vh`. No new typedefs.
- Storage, pointers and counter stay inline. No sub-module: the block is too small to justify one.
- Entry fields are stored as separate arrays so synthesis can map inst/pc into LUTRAM.

## Test plan
- Reset: hold resetn=0 mid-stream → valid_d=0, inst_d=32'h03400000, ready=1, count=0 with no clock edge required.
- Fill/drain: stall=1, push pc 0x1c000000..0x1c00000c → count=4, ready=0, fifth push ignored. Release stall → head PCs appear in order, one per cycle, then valid_d=0.
- Concurrent: count=2, push and pop in the same cycle → count stays 2, head advances to next PC, new entry lands at tail.
- Wrap: 10 push/pop pairs with count oscillating 1–3 → every PC and inst emerges once, in order, across pointer wrap.
- Flush: count=3 with push and pop asserted plus flush=1 → next cycle count=0, valid_d=0, pushed entry never appears.
- Exception tag: push entry with excp=1 between two normal entries → excp_d=1 exactly when that PC is at the head.
